morra_cinese_param: RTL
=======================

// Module: morra_cinese_param
// PURPOSE
// - Parametrised rock-paper-scissors match referee; successor of the fixed 2-player game FSM.
// - Scores a sequence of manches between two players and declares the match result.
// - Match length, minimum manche count, winning lead and the no-repeat rule are all configurable.
// - Adds a valid/start handshake, running scores and a manche counter.
// - Sits between player input logic and the score/display logic.
// PARAMETERS
// - MAX_BASE   4  offset added to cfg_max: manche_max = MAX_BASE + cfg_max
// - CFG_W      4  width of cfg_max
// - MIN_MANCHE 4  counted manches required before a lead can end the match early
// - LEAD_WIN   2  points lead that ends the match early (>=1)
// - NO_REPEAT  1  1: the last manche winner may not replay their winning move
// - CNT_W      $clog2(MAX_BASE+2**CFG_W)+1  width of counters/scores (derived, do not override)
// PORTS
// - clk        in   1      clock, rising edge
// - reset_n    in   1      asynchronous reset, active low
// - start      in   1      new-match strobe; samples cfg_max
// - cfg_max    in   CFG_W  match length offset
// - valid      in   1      primo/secondo carry a move this cycle
// - primo      in   2      player 1 move: 00 none, 01 sasso, 10 carta, 11 forbice
// - secondo    in   2      player 2 move, same coding
// - manche     out  2      last manche result: 00 non valida, 01 g1, 10 g2, 11 pareggio
// - manche_vld out  1      1-cycle pulse: manche updated
// - partita    out  2      00 in corso, 01 g1 wins, 10 g2 wins, 11 pareggio
// - punti1     out  CNT_W  player 1 manche wins
// - punti2     out  CNT_W  player 2 manche wins
// - n_manche   out  CNT_W  counted manches (excluding non valida)
// BEHAVIOUR
// - Reset (async assert, sync deassert at clk): state=IDLE.
//   Outputs: manche=00, manche_vld=0, partita=00, punti1/2=0, n_manche=0. Last-winner memory cleared.
// - States: IDLE -(start)-> PLAY -(end condition)-> DONE -(start)-> PLAY.
// - start in any state:
//   - Latches manche_max = MAX_BASE + cfg_max (zero-extended to CNT_W).
//   - Clears scores, n_manche, partita, manche and the last-winner memory.
//   - Enters PLAY next cycle.
//   - start mid-PLAY aborts the match with no result.
//   - start+valid in the same cycle: start wins, the move is dropped.
// - valid is accepted only in PLAY; ignored in IDLE/DONE (no manche_vld).
// - Accepted move, registered, 1-cycle latency: manche and manche_vld are set on the next edge.
// - Manche non valida (00) when:
//   - either move is 00, or
//   - NO_REPEAT=1 and the previous winner replays the move that won the last manche.
//   - Non valida: counters unchanged; last-winner memory unchanged.
// - Valid manche: winning pairs are sasso>forbice, forbice>carta, carta>sasso. Equal moves give pareggio.
//   - n_manche increments.
//   - The winner's score increments and the winner and move are stored.
//   - Pareggio clears the last-winner memory.
// - End check, same edge as the valid manche (partita updates together with manche_vld):
//   - n_manche_new >= MIN_MANCHE and |punti1-punti2| >= LEAD_WIN: partita = leader, go DONE.
//   - Else n_manche_new == manche_max: partita = leader, or 11 if scores are equal; go DONE.
//   - Early-lead check has priority when both conditions hold.
// - manche_max < MIN_MANCHE is legal: only the manche_max limit can end the match.
// - DONE holds all outputs stable until start or reset.
// - Counters never wrap: CNT_W covers manche_max.
// TESTING
// - Reset mid-PLAY: drop reset_n asynchronously between edges -> all outputs 0 immediately, state IDLE; valid ignored until start.
// - start cfg_max=0, then moves (01,10),(11,10),(01,11),(11,11),(01,01):
//   - manche 10, then 00 (g2 repeats carta; n_manche stays 1), then 01, 11, 11.
//   - Final n_manche=4, punti 1/1, partita=11 at manche_max=4.
// - start cfg_max=2, then g2 wins (01,10),(10,11),(11,01):
//   - After the 3rd manche punti2=3, but n_manche=3<4: partita stays 00.
//   - 4th manche g2 -> n_manche=4, lead 4 -> partita=10.
// - start cfg_max=1, alternate g1/g2 wins for 5 manches -> partita=01 (3-2) exactly at n_manche=5.
//   - Any valid afterwards -> no manche_vld; outputs frozen.
// - start asserted with valid=1 (01,10) in PLAY -> move dropped; scores 0, partita 00, n_manche 0.
// - NO_REPEAT=0 build: g2 wins with carta twice in a row -> both manches counted (punti2=2).
// - primo=00 with valid -> manche=00, manche_vld=1, counters unchanged.

Source files
------------

// File: rtl/morra_cinese_param.sv
// rtl/morra_cinese_param.sv - parametrised rock-paper-scissors match referee
// Scores manches between two players, tracks running scores and declares the match result.
module morra_cinese_param #(
  parameter int MAX_BASE   = 4,
  parameter int CFG_W      = 4,
  parameter int MIN_MANCHE = 4,
  parameter int LEAD_WIN   = 2,
  parameter int NO_REPEAT  = 1,
  parameter int CNT_W      = $clog2(MAX_BASE + 2**CFG_W) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_max,
  input  logic             valid,
  input  logic [1:0]       primo,
  input  logic [1:0]       secondo,
  output logic [1:0]       manche,
  output logic             manche_vld,
  output logic [1:0]       partita,
  output logic [CNT_W-1:0] punti1,
  output logic [CNT_W-1:0] punti2,
  output logic [CNT_W-1:0] n_manche
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MANCHE);
  localparam logic [CNT_W-1:0] LEAD_C = CNT_W'(LEAD_WIN);
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(MAX_BASE);

  state_t           state, state_nx;
  logic [CNT_W-1:0] max_q, max_nx;
  logic [CNT_W-1:0] p1_q, p1_nx, p2_q, p2_nx, n_q, n_nx;
  logic [1:0]       manche_q, manche_nx, partita_q, partita_nx;
  logic             vld_q, vld_nx;
  logic [1:0]       last_win_q, last_win_nx, last_move_q, last_move_nx;
  logic [CNT_W-1:0] lead;
  logic [1:0]       leader;
  logic             foul;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) ||
           (a == 2'b10 && b == 2'b01);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      max_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      n_q         <= '0;
      manche_q    <= 2'b00;
      partita_q   <= 2'b00;
      vld_q       <= 1'b0;
      last_win_q  <= 2'b00;
      last_move_q <= 2'b00;
    end else begin
      state       <= state_nx;
      max_q       <= max_nx;
      p1_q        <= p1_nx;
      p2_q        <= p2_nx;
      n_q         <= n_nx;
      manche_q    <= manche_nx;
      partita_q   <= partita_nx;
      vld_q       <= vld_nx;
      last_win_q  <= last_win_nx;
      last_move_q <= last_move_nx;
    end
  end

  // The last winner may not replay the move that won the previous manche.
  assign foul = (NO_REPEAT != 0) &&
                ((last_win_q == 2'b01 && primo == last_move_q) ||
                 (last_win_q == 2'b10 && secondo == last_move_q));

  always_comb begin
    state_nx     = state;
    max_nx       = max_q;
    p1_nx        = p1_q;
    p2_nx        = p2_q;
    n_nx         = n_q;
    manche_nx    = manche_q;
    partita_nx   = partita_q;
    vld_nx       = 1'b0;
    last_win_nx  = last_win_q;
    last_move_nx = last_move_q;
    lead         = '0;
    leader       = 2'b11;

    if (start) begin
      max_nx       = BASE_C + CNT_W'(cfg_max);
      p1_nx        = '0;
      p2_nx        = '0;
      n_nx         = '0;
      manche_nx    = 2'b00;
      partita_nx   = 2'b00;
      last_win_nx  = 2'b00;
      last_move_nx = 2'b00;
      state_nx     = PLAY;
    end else if (valid && state == PLAY) begin
      vld_nx = 1'b1;
      if (primo == 2'b00 || secondo == 2'b00 || foul) begin
        manche_nx = 2'b00;
      end else begin
        n_nx = n_q + 1'b1;
        if (primo == secondo) begin
          manche_nx   = 2'b11;
          last_win_nx = 2'b00;
        end else if (beats(primo, secondo)) begin
          manche_nx    = 2'b01;
          p1_nx        = p1_q + 1'b1;
          last_win_nx  = 2'b01;
          last_move_nx = primo;
        end else begin
          manche_nx    = 2'b10;
          p2_nx        = p2_q + 1'b1;
          last_win_nx  = 2'b10;
          last_move_nx = secondo;
        end

        // End check uses the post-manche scores; the early lead takes priority.
        lead   = (p1_nx >= p2_nx) ? (p1_nx - p2_nx) : (p2_nx - p1_nx);
        leader = (p1_nx > p2_nx) ? 2'b01 : (p2_nx > p1_nx) ? 2'b10 : 2'b11;
        if (n_nx >= MIN_C && lead >= LEAD_C) begin
          partita_nx = leader;
          state_nx   = DONE;
        end else if (n_nx == max_q) begin
          partita_nx = leader;
          state_nx   = DONE;
        end
      end
    end
  end

  assign manche     = manche_q;
  assign manche_vld = vld_q;
  assign partita    = partita_q;
  assign punti1     = p1_q;
  assign punti2     = p2_q;
  assign n_manche   = n_q;

endmodule
